// File: rtl/mux_ser_pkg.sv
// Shared types and constants for the 16:1 mux word serializer.
// Optional feature macro: MUX_SER_PARITY_EN (adds an even-parity trailer beat).
package mux_ser_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 4;
    localparam logic [SEL_W-1:0] SEL_LAST = 4'd15;

`ifdef MUX_SER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    // Even parity of a full word.
    function automatic logic word_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/mux_sel_counter.sv
// Select-index counter: synchronous clear, enable, terminal-count flag.
// count_nxt_c lets the owner pre-compute outputs that depend on the next index.
module mux_sel_counter
    import mux_ser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] count,
    output logic [SEL_W-1:0] count_nxt_c,
    output logic             tc_c
);

    // Next index: clear has priority over increment.
    always_comb begin
        count_nxt_c = count;
        if (clr) begin
            count_nxt_c = '0;
        end else if (en) begin
            count_nxt_c = count + SEL_W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt_c;
        end
    end

    assign tc_c = (count == SEL_LAST);

endmodule

// File: rtl/mux_word_serializer.sv
// Parallel-to-serial front end for the 16:1 mux datapath.
// Optional feature macro: MUX_SER_PARITY_EN (17th beat carries even parity).
// Every output is a flop loaded from the next-state decode, so out_bit and
// in_ready have no combinational path from any input.
module mux_word_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_inputs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [SEL_W-1:0] select_line,
    output logic             busy
);

    import mux_ser_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   word_q;
    logic [WIDTH-1:0]   word_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic [SEL_W-1:0]   sel_d;
    logic               sel_tc;

    logic               in_ready_d;
    logic               out_valid_d;
    logic               out_bit_d;
    logic               out_last_d;
    logic               busy_d;

    // Select index counter; its registered count is the exported select_line.
    mux_sel_counter u_sel_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .count       (select_line),
        .count_nxt_c (sel_d),
        .tc_c        (sel_tc)
    );

    // State and word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Next-state, counter control and next-output decode.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d  = data_inputs;
                    cnt_clr = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (out_ready) begin
                    if (sel_tc) begin
`ifdef MUX_SER_PARITY_EN
                        // Index holds at 15 through the parity beat.
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
                        cnt_clr = 1'b1;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
`ifdef MUX_SER_PARITY_EN
            S_PARITY: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        // Outputs for the coming cycle, decoded from the next state.
        case (state_d)
            S_IDLE: begin
                in_ready_d = 1'b1;
            end
            S_SHIFT: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                out_bit_d   = word_d[sel_d];
`ifndef MUX_SER_PARITY_EN
                out_last_d  = (sel_d == SEL_LAST);
`endif
            end
`ifdef MUX_SER_PARITY_EN
            S_PARITY: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                out_bit_d   = word_parity(word_d);
                out_last_d  = 1'b1;
            end
`endif
            default: begin
                in_ready_d = 1'b1;
            end
        endcase
    end

    // Registered handshake and data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_bit   <= out_bit_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Self-checking bench for mux_word_serializer (scoreboard of expected beats).
// Build with +define+MUX_SER_PARITY_EN to cover the parity trailer.
module tb_mux_word_serializer;

`ifdef MUX_SER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    typedef struct packed {
        logic       b;
        logic [3:0] sel;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_inputs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_bit;
    logic        out_last;
    logic [3:0]  select_line;
    logic        busy;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    mux_word_serializer #(.WIDTH(16), .SEL_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_inputs (data_inputs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_last    (out_last),
        .select_line (select_line),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: expected beat stream for one word.
    task automatic push_word(input logic [15:0] w);
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e.b    = w[i];
            e.sel  = 4'(i);
`ifdef MUX_SER_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == 15);
`endif
            exp_q.push_back(e);
        end
`ifdef MUX_SER_PARITY_EN
        e.b    = ^w;
        e.sel  = 4'd15;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_bit, out_last, select_line, busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b vld=%0b bit=%0b last=%0b sel=%0d busy=%0b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_bit, out_last, select_line, busy);
        end
    endtask

    task automatic test_basic();
        beat_t e;
        out_ready   = 1'b1;
        push_word(16'hAAAA);
        in_valid    = 1'b1;
        data_inputs = 16'hAAAA;
        for (int k = 1; k <= NB + 1; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (k <= NB) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_valid, in_ready, busy, out_bit, select_line, out_last} !== {1'b1, 1'b0, 1'b1, e.b, e.sel, e.last}) begin
                    errors++;
                    $display("FAIL basic_beat%0d got vld=%0b rdy=%0b busy=%0b bit=%0b sel=%0d last=%0b want 1 0 1 bit=%0b sel=%0d last=%0b",
                             k, out_valid, in_ready, busy, out_bit, select_line, out_last, e.b, e.sel, e.last);
                end
            end else begin
                checks++;
                if ({in_ready, out_valid, busy, select_line} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
                    errors++;
                    $display("FAIL basic_idle got rdy=%0b vld=%0b busy=%0b sel=%0d want 1 0 0 0",
                             in_ready, out_valid, busy, select_line);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rebuilt = '0;
        int          n = 0;
        int          cyc = 0;
        push_word(16'h00F0);
        in_valid    = 1'b1;
        data_inputs = 16'h00F0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((exp_q.size() != 0) && (cyc < 400)) begin
            out_ready = 1'($urandom_range(0, 1));
            checks++;
            if (!out_valid || {out_bit, select_line, out_last} !== {exp_q[0].b, exp_q[0].sel, exp_q[0].last}) begin
                errors++;
                $display("FAIL bp_hold beat%0d got vld=%0b bit=%0b sel=%0d last=%0b want vld=1 bit=%0b sel=%0d last=%0b",
                         n, out_valid, out_bit, select_line, out_last, exp_q[0].b, exp_q[0].sel, exp_q[0].last);
            end
            if (out_valid && out_ready) begin
                if (n < 16) rebuilt[n] = out_bit;
                n++;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_timeout got %0d beats left want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rebuilt !== 16'h00F0) begin
            errors++;
            $display("FAIL bp_word got %h want 00f0", rebuilt);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_input();
        logic [15:0] rebuilt = '0;
        int          n = 0;
        beat_t       e;
        out_ready   = 1'b1;
        push_word(16'h1234);
        in_valid    = 1'b1;
        data_inputs = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= NB + 4; k++) begin
            if (k == 3) begin
                in_valid    = 1'b1;
                data_inputs = 16'hFFFF;
            end else begin
                in_valid    = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ign_extra_beat got bit=%0b sel=%0d want no beat", out_bit, select_line);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_bit, select_line, out_last} !== {e.b, e.sel, e.last}) begin
                        errors++;
                        $display("FAIL ign_beat%0d got bit=%0b sel=%0d last=%0b want bit=%0b sel=%0d last=%0b",
                                 n, out_bit, select_line, out_last, e.b, e.sel, e.last);
                    end
                    if (n < 16) rebuilt[n] = out_bit;
                    n++;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if ((rebuilt !== 16'h1234) || (n != NB)) begin
            errors++;
            $display("FAIL ign_word got %h beats=%0d want 1234 beats=%0d", rebuilt, n, NB);
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        beat_t e;
        int    n = 0;
        int    cyc = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        data_inputs = 16'h5A5A;
        @(negedge clk);
        in_valid = 1'b0;
        while ((select_line != 4'd7) && (cyc < 40)) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_bit, out_last, select_line, busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_values got rdy=%0b vld=%0b bit=%0b last=%0b sel=%0d busy=%0b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_bit, out_last, select_line, busy);
        end
        @(negedge clk);
        rst         = 1'b0;
        in_valid    = 1'b1;
        data_inputs = 16'h0003;
        push_word(16'h0003);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 60)) begin
            checks++;
            e = exp_q.pop_front();
            if ({out_valid, out_bit, select_line, out_last} !== {1'b1, e.b, e.sel, e.last}) begin
                errors++;
                $display("FAIL midrst_beat%0d got vld=%0b bit=%0b sel=%0d last=%0b want vld=1 bit=%0b sel=%0d last=%0b",
                         n, out_valid, out_bit, select_line, out_last, e.b, e.sel, e.last);
            end
            n++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!in_ready || out_valid) begin
            errors++;
            $display("FAIL midrst_end got rdy=%0b vld=%0b want 1 0", in_ready, out_valid);
        end
    endtask

`ifdef MUX_SER_PARITY_EN
    task automatic test_parity(input logic [15:0] w, input logic par);
        int   n = 0;
        int   cyc = 0;
        logic last_bit = 1'b0;
        logic last_flag = 1'b0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        data_inputs = w;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid && (cyc < 40)) begin
            last_bit  = out_bit;
            last_flag = out_last;
            n++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ((n != 17) || (last_bit !== par) || (last_flag !== 1'b1)) begin
            errors++;
            $display("FAIL parity_%h got beats=%0d parity=%0b last=%0b want beats=17 parity=%0b last=1",
                     w, n, last_bit, last_flag, par);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_input();
        test_mid_reset();
`ifdef MUX_SER_PARITY_EN
        test_parity(16'h0001, 1'b1);
        test_parity(16'h0003, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_word_serializer.md
# mux_word_serializer

Parallel-to-serial front end for the 16:1 mux datapath. Accepts a 16-bit word over a valid/ready handshake, steps a 4-bit select index through positions 0..15, and emits one selected bit per accepted output beat with valid/ready flow control. The registered select index is exported on `select_line` so a downstream 16:1 mux can share it.

## Interface
Parameters:
- `WIDTH`, 16: input word width; fixed at 16 for this revision.
- `SEL_W`, 4: select index width; must equal clog2(`WIDTH`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `data_inputs`  in  16  upstream word; bit 0 is sent first.
- `out_valid`  out  1  `out_bit` valid.
- `out_ready`  in  1  downstream accepts the current beat.
- `out_bit`  out  1  serial data, equal to `word_q[select_line]`.
- `out_last`  out  1  marks the final beat of a word.
- `select_line`  out  4  current select index, registered.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE -> SHIFT -> (PARITY when `MUX_SER_PARITY_EN` is defined) -> IDLE.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: latch `data_inputs` into `word_q`, set `select_line`=0, go to SHIFT.
- SHIFT:
  - `out_valid`=1, `out_bit`=`word_q[select_line]`, `in_ready`=0.
  - A beat completes on `out_valid && out_ready`. Then `select_line` increments by 1.
  - At `select_line`==15:
    - Without parity: `out_last`=1 on this beat; the handshake returns the state to IDLE and `select_line` to 0.
    - With parity: `out_last`=0; the handshake goes to PARITY and `select_line` holds at 15.
- PARITY (only when `MUX_SER_PARITY_EN` is defined):
  - `out_valid`=1, `out_bit`=^`word_q` (even parity), `out_last`=1.
  - Handshake returns the state to IDLE and `select_line` to 0.
- Backpressure: while `out_ready`=0, `out_bit`, `out_last` and `select_line` hold stable, and `out_valid` stays high.
- `in_valid` is ignored while not in IDLE. Upstream must hold the word until it sees `in_ready`.
- `select_line` arithmetic is 4-bit unsigned. Wrap from 15 never occurs because the FSM leaves SHIFT first.
- `in_ready` is purely state-decoded, with no combinational path from `out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_bit`=0, `out_last`=0, `select_line`=0, `busy`=0, `word_q`=0, state IDLE.
- Reset mid-word: the word is abandoned immediately (asynchronous), with no partial beats after `rst` deasserts. The first edge after deassertion may accept a new word.
- Latency: word accepted at edge N; bit 0 is valid in the cycle after edge N.
- Throughput with `out_ready` held high:
  - 17 cycles per word (16 beats plus 1 IDLE cycle).
  - 18 cycles per word with parity.
- No overlap between words. The last-beat handshake and the next input acceptance occur on different edges.
- `out_bit` is driven from registered state only; it is glitch-free across beats.

## Configuration
- Macro `MUX_SER_PARITY_EN`.
- Defined: the PARITY state exists; each word emits 17 beats, with `out_last` on the parity beat.
- Undefined: the PARITY state, parity logic and its state encoding are compiled out; 16 beats per word, with `out_last` on bit 15.

## Structure
- Shared package `mux_ser_pkg` holds:
  - the state enum (`S_IDLE`, `S_SHIFT`, `S_PARITY`);
  - localparams `WORD_W`=16, `SEL_W`=4 and `SEL_LAST`=4'd15.
- One sub-module, `mux_sel_counter`: a 4-bit counter with synchronous clear, enable and a terminal-count flag, driving `select_line`.
- The FSM, word register and output mux stay in the top module.

## Test plan
- Reset: assert `rst` for 3 cycles, then check all outputs equal their reset values, including `in_ready`=1 and `select_line`=0.
- Basic: load 16'hAAAA with `out_ready`=1.
  - Expect `out_bit` sequence 0,1,0,1,… for 16 beats.
  - Expect `select_line` 0..15 and `out_last` only on beat 15.
  - Expect `in_ready` high again on the 17th cycle after acceptance.
- Backpressure: load 16'h00F0 and toggle `out_ready` pseudo-randomly.
  - Every beat's `out_bit`/`select_line` must hold until its handshake.
  - The reconstructed word must equal 16'h00F0.
- Ignored input: pulse `in_valid` with 16'hFFFF during SHIFT of 16'h1234. Output must remain 16'h1234, with no extra word accepted.
- Mid-word reset: assert `rst` at beat 7 of 16'h5A5A.
  - Outputs must reach reset values immediately.
  - A subsequent 16'h0003 must serialize as 1,1,0,… starting from `select_line`=0.
- Parity (`MUX_SER_PARITY_EN`):
  - 16'h0001 gives 17 beats, ending with parity 1 and `out_last` high.
  - 16'h0003 gives parity 0.
